// File: rtl/uart_pkg.sv
// uart_pkg: shared parity encodings, transmitter FSM states and parameter legality check
// No ports; imported by uart_tx_fifo and uart_tx_param.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;
  function automatic bit params_ok(int data_bits, int clks_per_bit, int parity, int stop_bits, int fifo_depth);
    return data_bits >= 5 && data_bits <= 9 && clks_per_bit >= 2 && parity >= PAR_NONE && parity <= PAR_EVEN &&
           (stop_bits == 1 || stop_bits == 2) && fifo_depth >= 2 && (fifo_depth & (fifo_depth - 1)) == 0;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with wrap-bit pointers and an occupancy count
// Ports: clk, reset (async high), push/wdata in, pop/rdata out (first-word fall-through), count, full, empty.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign count = wr_ptr - rd_ptr;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = wr_ptr == rd_ptr;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter fed by a valid/ready input FIFO
// Ports: clk, reset (async high), tx_data/tx_valid/tx_ready word input, serial_out line (idle high),
// busy (frame on the line), fifo_count (words waiting).
module uart_tx_param import uart_pkg::*; #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  if (!params_ok(DATA_BITS, CLKS_PER_BIT, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_params
    $error("uart_tx_param: illegal parameter combination");
  end
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, fifo_data;
  logic par_bit, par_n, line_n, pop, last_baud, last_stop, fifo_full, fifo_empty;
  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(tx_valid),
    .wdata(tx_data),
    .pop(pop),
    .rdata(fifo_data),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign tx_ready = !fifo_full;
  assign busy = state != S_IDLE;
  // serial_out is registered from the next-state level so the start bit appears on the pop edge itself
  always_comb begin
    last_baud = baud == BAUD_LAST;
    last_stop = state == S_STOP && last_baud && bit_idx == STOP_LAST;
    pop = (state == S_IDLE || last_stop) && !fifo_empty;
    state_n = state;
    baud_n = (state == S_IDLE || last_baud) ? '0 : baud + 1'b1;
    bit_n = bit_idx;
    shreg_n = pop ? fifo_data : shreg;
    par_n = pop ? ^fifo_data ^ (PARITY == PAR_ODD) : par_bit;
    case (state)
      S_IDLE:  state_n = pop ? S_START : S_IDLE;
      S_START: state_n = last_baud ? S_DATA : S_START;
      S_DATA:
        if (last_baud) begin
          shreg_n = shreg >> 1;
          bit_n = bit_idx == BIT_LAST ? '0 : bit_idx + 1'b1;
          state_n = bit_idx != BIT_LAST ? S_DATA : PARITY != PAR_NONE ? S_PAR : S_STOP;
        end
      S_PAR:   state_n = last_baud ? S_STOP : S_PAR;
      S_STOP:
        if (last_baud) begin
          bit_n = last_stop ? '0 : bit_idx + 1'b1;
          state_n = !last_stop ? S_STOP : pop ? S_START : S_IDLE;
        end
      default: state_n = S_IDLE;
    endcase
    line_n = state_n == S_START ? 1'b0 : state_n == S_DATA ? shreg_n[0] : state_n == S_PAR ? par_n : 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      baud <= '0;
      bit_idx <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_idx <= bit_n;
      shreg <= shreg_n;
      par_bit <= par_n;
      serial_out <= line_n;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench over four transmitter configurations (8N1, 8E1, 8O1, 5N2)
module tb_uart_tx_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [8:0] tx_data [4];
  logic tx_valid [4];
  logic tx_ready [4];
  logic serial_out [4];
  logic busy [4];
  logic [2:0] fifo_count [4];
  int compared = 0;
  int mismatched = 0;
  string q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  function automatic void q_push(int d, string s);
    case (d)
      0: q0.push_back(s);
      1: q1.push_back(s);
      2: q2.push_back(s);
      default: q3.push_back(s);
    endcase
  endfunction

  function automatic int q_size(int d);
    return d == 0 ? q0.size() : d == 1 ? q1.size() : d == 2 ? q2.size() : q3.size();
  endfunction

  function automatic string q_pop(int d);
    string s;
    case (d)
      0: s = q0.pop_front();
      1: s = q1.pop_front();
      2: s = q2.pop_front();
      default: s = q3.pop_front();
    endcase
    return s;
  endfunction

  // Each DUT gets its own monitor: it pops the expected bit string (start..stop, one char per bit time)
  // when a start bit appears and checks every cycle of the frame, then the cycle after the last stop bit.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DB = g == 3 ? 5 : 8;
    localparam int PB = g == 1 ? 2 : g == 2 ? 1 : 0;
    localparam int SB = g == 3 ? 2 : 1;
    uart_tx_param #(.DATA_BITS(DB), .CLKS_PER_BIT(4), .PARITY(PB), .STOP_BITS(SB), .FIFO_DEPTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .tx_data(tx_data[g][DB-1:0]),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]),
      .serial_out(serial_out[g]),
      .busy(busy[g]),
      .fifo_count(fifo_count[g])
    );
    initial begin : mon
      string s;
      bit bad, gap, abort;
      int pos;
      logic want, got_line, got_busy;
      gap = 0;
      forever begin
        @(negedge clk);
        if (gap && !reset) begin
          compared++;
          if (busy[g] ? serial_out[g] !== 1'b0 : serial_out[g] !== 1'b1) begin
            mismatched++;
            $display("FAIL after_stop dut%0d: line %b busy %b, want start bit if busy else idle high", g, serial_out[g], busy[g]);
          end
        end
        gap = 0;
        if (!reset && serial_out[g] === 1'b0) begin
          if (q_size(g) == 0) begin
            compared++;
            mismatched++;
            $display("FAIL spurious_frame dut%0d: start bit with no word expected", g);
            while (busy[g] === 1'b1 && !reset) @(negedge clk);
          end else begin
            s = q_pop(g);
            bad = 0;
            abort = 0;
            for (int c = 0; c < 4 * s.len(); c++) begin
              if (c > 0) @(negedge clk);
              if (reset) begin
                abort = 1;
                break;
              end
              if (!bad && (serial_out[g] !== (s.getc(c / 4) == "1") || busy[g] !== 1'b1)) begin
                bad = 1;
                pos = c;
                got_line = serial_out[g];
                got_busy = busy[g];
                want = s.getc(c / 4) == "1";
              end
            end
            if (!abort) begin
              compared++;
              gap = 1;
              if (bad) begin
                mismatched++;
                $display("FAIL frame dut%0d %s: cycle %0d got line %b busy %b, want line %b busy 1", g, s, pos, got_line, got_busy, want);
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(string name, int got, int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Leaves tx_valid high and returns #1 after the accepting edge, so consecutive calls push back-to-back.
  task automatic send(int d, logic [8:0] w, string exp);
    int n;
    tx_data[d] = w;
    tx_valid[d] = 1'b1;
    n = 0;
    while (!tx_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready[d]) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout dut%0d: tx_ready stayed 0 for %0d cycles", d, n);
    end else begin
      @(posedge clk);
      q_push(d, exp);
      #1;
    end
  endtask

  task automatic busy_len(int d, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy[d] || n >= 1000) break;
      n++;
    end
  endtask

  task automatic wait_drain(int d);
    int n;
    n = 0;
    while ((q_size(d) != 0 || busy[d]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout dut%0d: %0d frames still queued", d, q_size(d));
    end
  endtask

  initial begin
    int n;
    logic [8:0] fw [6];
    string fs [6];
    int fc [6];
    fw = '{9'h01, 9'h80, 9'h55, 9'hAA, 9'hFF, 9'h3C};
    fs = '{"0100000001", "0000000011", "0101010101", "0010101011", "0111111111", "0001111001"};
    fc = '{1, 1, 2, 3, 4, 4};
    for (int d = 0; d < 4; d++) begin
      tx_valid[d] = 1'b0;
      tx_data[d] = '0;
    end
    #1 reset = 1'b1;
    #2;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_line_dut%0d", d), serial_out[d], 1);
      chk($sformatf("rst_busy_dut%0d", d), busy[d], 0);
      chk($sformatf("rst_count_dut%0d", d), fifo_count[d], 0);
      chk($sformatf("rst_ready_dut%0d", d), tx_ready[d], 1);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    send(0, 9'hF0, "0000011111");
    tx_valid[0] = 1'b0;
    chk("lat_accept_count", fifo_count[0], 1);
    chk("lat_accept_line", serial_out[0], 1);
    chk("lat_accept_busy", busy[0], 0);
    @(posedge clk);
    #1;
    chk("lat_pop_count", fifo_count[0], 0);
    chk("lat_pop_line", serial_out[0], 0);
    chk("lat_pop_busy", busy[0], 1);
    busy_len(0, n);
    chk("busy_cycles_8n1", n, 40);

    send(0, 9'hF0, "0000011111");
    send(0, 9'h0F, "0111100001");
    tx_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_pre_line", serial_out[0], 0);
    chk("midrst_pre_count", fifo_count[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_line", serial_out[0], 1);
    chk("midrst_count", fifo_count[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_ready", tx_ready[0], 1);
    q0.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(0, 9'hD3, "0110010111");
    tx_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    busy_len(0, n);
    chk("busy_cycles_after_reset", n, 40);

    send(0, 9'hF0, "0000011111");
    send(0, 9'hD3, "0110010111");
    tx_valid[0] = 1'b0;
    chk("b2b_busy_start", busy[0], 1);
    busy_len(0, n);
    chk("busy_cycles_back_to_back", n, 80);

    send(1, 9'hD3, "01100101111");
    tx_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    busy_len(1, n);
    chk("busy_cycles_8e1", n, 44);
    send(2, 9'hD3, "01100101101");
    tx_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    busy_len(2, n);
    chk("busy_cycles_8o1", n, 44);
    send(3, 9'h15, "01010111");
    tx_valid[3] = 1'b0;
    @(posedge clk);
    #1;
    busy_len(3, n);
    chk("busy_cycles_5n2", n, 32);

    for (int i = 0; i < 6; i++) begin
      send(0, fw[i], fs[i]);
      chk($sformatf("full_count_%0d", i), fifo_count[0], fc[i]);
      if (i == 4) chk("full_ready", tx_ready[0], 0);
    end
    tx_valid[0] = 1'b0;

    for (int d = 0; d < 4; d++) wait_drain(d);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) chk($sformatf("leftover_dut%0d", d), q_size(d), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    mismatched++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: the next generation of the team's fixed 8N1 transmit block. A small input FIFO with a valid/ready handshake replaces the separate load/byte-ready/start strobes. It adds configurable data width, parity, stop bits and baud divisor, and sends back-to-back frames with no idle gap. It sits between the router's byte-stream producer and the serial pin.

## Interface
- `DATA_BITS`, 8: payload bits per frame, legal 5–9.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit, legal ≥2.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 4: entries, power of two, ≥2.
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `tx_data` input DATA_BITS: word to send.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: FIFO can accept a word. Combinational from count: `count < FIFO_DEPTH`.
- `serial_out` output 1: registered line output, idle high.
- `busy` output 1: a frame is on the line (state ≠ IDLE).
- `fifo_count` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push: on an edge with `tx_valid && tx_ready`. Data is held stable by the producer until accepted.
- Pop: when the shifter is in IDLE, or on the final cycle of the last stop bit, and the FIFO is non-empty.
- Simultaneous push and pop: count unchanged, both take effect.
- Full FIFO: `tx_ready`=0 and `tx_valid` is ignored.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START on pop.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA sends bits LSB first, one per CLKS_PER_BIT cycles. After DATA_BITS bits it moves to PAR if PARITY≠0, else STOP.
  - PAR → STOP after one bit time.
  - STOP holds high for STOP_BITS×CLKS_PER_BIT cycles. It then goes to START if a word was popped, else IDLE.
- Line levels: start bit 0, stop bits 1, IDLE 1.
- Parity bit: XOR of the data bits for even, inverted XOR for odd.
- Counters: baud counter 0..CLKS_PER_BIT−1, bit index 0..DATA_BITS−1. Both wrap to 0 at each bit boundary.
- Reset, including mid-frame: `serial_out`=1 immediately (async), FIFO emptied, state IDLE, counters 0.

## Timing
- Reset values: `serial_out`=1, `busy`=0, `fifo_count`=0, `tx_ready`=1.
- Latency (idle, empty FIFO): word accepted on edge N, popped on edge N+1. `serial_out` goes low and `busy` high from edge N+1.
- Frame length: CLKS_PER_BIT×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles, exactly.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle. `busy` stays high throughout.
- `busy` falls on the edge after the last stop-bit cycle when the FIFO is empty.
- Throughput: one frame per frame length. The FIFO absorbs bursts of up to FIFO_DEPTH words.

## Structure
- Package `uart_pkg` holds:
  - parity encodings `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - FSM state constants (3-bit);
  - a parameter legality check function.
- Sub-module `uart_tx_fifo`: synchronous FIFO, parameters WIDTH and DEPTH. It has wrap-around pointers with an extra MSB for full/empty and a `count` output.
- Top level holds the FSM, baud counter, bit counter, shift register and parity accumulator.

## Test plan
- Reset: hold `reset` for 5 cycles, then assert it again mid-frame. Required: `serial_out`=1 and `fifo_count`=0 asynchronously; the next frame after release starts clean.
- 8N1, CLKS_PER_BIT=4, send 0xF0. Required: line reads 0,0,0,0,0,1,1,1,1,1, each level held 4 cycles; start bit begins 1 cycle after accept; `busy` high for 40 cycles.
- Back-to-back: push 0xF0 then 0xD3 on consecutive cycles. Required: 0xD3's start bit begins on the cycle after 0xF0's stop bit; `busy` never drops.
- Even parity, 0xD3 (five 1s). Required: parity bit 1. Odd parity: 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- Full FIFO: DEPTH=4; push 6 words with `tx_valid` held. Required: `tx_ready`=0 while count=4; no word lost or duplicated; all 6 serialised in order.
- DATA_BITS=5, STOP_BITS=2, send 0x15. Required: data bits 1,0,1,0,1, then 2×CLKS_PER_BIT cycles of stop high.
